data_sram_ctrl: RTL and testbench
=================================

# data_sram_ctrl

Memory-side responder for the MEM stage's data-memory request port: it accepts one word-aligned, byte-lane-selected load or store per transaction and executes it on an external asynchronous 32-bit SRAM through a multi-cycle state machine. While a transaction is in flight it raises a stall request to the pipeline stall controller. In the completion cycle it returns the full read word on `data_o`; the MEM stage extracts bytes and halfwords from that word itself. Byte lanes are big-endian: `sel_i[3]` and `data[31:24]` correspond to byte address offset 0.

## Interface
- `WAIT_CYCLES`, default 2: SRAM access strobe length in clocks, legal range 1..15.
- `ADDR_W`, default 20: SRAM word-address width.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `ce_i` input 1: request valid from the MEM stage.
- `we_i` input 1: 1 = store, 0 = load.
- `addr_i` input 32: byte address; bits [ADDR_W+1:2] select the word.
- `sel_i` input 4: byte-lane enables, big-endian order.
- `data_i` input 32: store data, already replicated or shifted into its lanes.
- `data_o` output 32: read word; valid in the DONE state.
- `stall_o` output 1: stall request to the pipeline controller.
- `sram_addr_o` output ADDR_W: SRAM word address.
- `sram_dq_i` input 32: SRAM data in.
- `sram_dq_o` output 32: SRAM data out.
- `sram_dq_oe` output 1: 1 = drive the data bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` outputs 1 each: active-low SRAM strobes.
- `sram_be_n` output 4: active-low byte enables; `sram_be_n[3]` = `dq[31:24]`.

## Operation
- **States:** IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit counter `cnt` times RD and WR_PULSE.
- **IDLE, `ce_i`=1:** latch `addr_i`, `we_i`, `sel_i` and `data_i` into internal registers. After acceptance the transaction always runs to completion, even if `ce_i` drops or the inputs change.
- **IDLE transitions:**
  - Load: go to RD with `cnt`=WAIT_CYCLES.
  - Store with `sel_i`=0000: go to DONE. No SRAM strobe is issued.
  - Any other store: go to WR_SETUP.
- **RD:**
  - Outputs: `sram_ce_n`=0, `sram_oe_n`=0, `sram_be_n`=0000, `sram_dq_oe`=0.
  - `cnt` decrements each cycle.
  - When `cnt`=1, capture `sram_dq_i` into the read register and go to DONE.
- **WR_SETUP (1 cycle):** `sram_ce_n`=0, `sram_oe_n`=1, `sram_we_n`=1, `sram_dq_oe`=1, `sram_dq_o` = store word; load `cnt`=WAIT_CYCLES.
- **WR_PULSE:** as WR_SETUP but `sram_we_n`=0. Lasts WAIT_CYCLES cycles, then go to WR_HOLD.
- **WR_HOLD (1 cycle):** `sram_we_n`=1. Data and address are still driven. Go to DONE.
- **DONE (1 cycle):** `stall_o`=0 and `data_o` = read register. Return to IDLE. A new request is seen in IDLE on the next cycle.
- **`stall_o`:** combinational; `(state==IDLE && ce_i) || (state!=IDLE && state!=DONE)`.
- **Strobes:** all SRAM strobes are registered, and glitch-free relative to `clk`.
- **Idle bus state:** in IDLE and DONE, `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=1111, `sram_dq_oe`=0.
- **Read register:** holds its value until the next RD capture.

## Timing
- **Reset values:** state IDLE, `data_o`=0, `stall_o`=0 (forced to 0 while `rst`=1), `sram_addr_o`=0, `sram_dq_o`=0, `sram_dq_oe`=0, `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=1111.
- **Load:** stall is high for 1+WAIT_CYCLES cycles; DONE is at cycle 1+WAIT_CYCLES after acceptance (cycle 0).
- **Store:** stall is high for 3+WAIT_CYCLES cycles; DONE is at cycle 3+WAIT_CYCLES.
- **Back-to-back requests:** the minimum gap is one cycle (DONE then IDLE accept). No request is lost while `ce_i` is held.
- **Reset mid-transaction:** on the next edge `sram_we_n` returns to 1 and `sram_dq_oe` to 0. The partially written word is undefined. No completion is reported.

## Configuration
- **`DSRAM_RMW_EN` undefined:** stores drive `sram_be_n` = ~`sel_i`.
- **`DSRAM_RMW_EN` defined:** the SRAM is treated as having no byte lanes.
  - A store with `sel_i`≠1111 and ≠0000 first runs RD.
  - In RD it merges per lane (sel ? `data_i` : SRAM) into the write register, then goes to WR_SETUP.
  - All writes use `sram_be_n`=0000.
  - Partial-store stall length becomes 4+2×WAIT_CYCLES.
  - `data_o` after such a store equals the pre-merge read word.
  - Full-word stores and loads are unchanged.

## Test plan
- **Full-word store:** `ce_i`=1, `we_i`=1, `addr_i`=0x00000010, `sel_i`=1111, `data_i`=0xDEADBEEF, WAIT_CYCLES=2 → `sram_addr_o`=0x00004, `sram_be_n`=0000, `sram_we_n` low cycles 2–3, `stall_o` high cycles 0–4, DONE at cycle 5.
- **Load after store:** load `addr_i`=0x00000010, `sel_i`=1111 → `stall_o` high cycles 0–2, `data_o`=0xDEADBEEF in cycle 3, `sram_we_n` never low.
- **Byte store:** SB with `addr_i`=0x00000011, `sel_i`=0100, `data_i`=0x55555555.
  - Without the macro: `sram_be_n`=1011.
  - With `DSRAM_RMW_EN`: read phase first, then `sram_be_n`=0000, `sram_dq_o`=0xDE55BEEF, stall 8 cycles.
  - Either way, a later LW returns 0xDE55BEEF.
- **Zero-lane store:** store with `sel_i`=0000 → no SRAM strobe, `stall_o` high 1 cycle, memory unchanged.
- **Reset mid-store:** `rst` asserted during WR_PULSE → next edge `sram_we_n`=1, `sram_dq_oe`=0, `stall_o`=0, `data_o`=0; a following load from another address completes normally.
- **Back-to-back:** load then store with `ce_i` held high → second request accepted the cycle after the first DONE, and `stall_o` is low in exactly one cycle between them.

Source files
------------

// File: rtl/data_sram_ctrl.sv
// Data-memory responder: runs one load/store per request on an async 32-bit SRAM with registered strobes.
// Optional build macro DSRAM_RMW_EN: partial stores become read-merge-write with all byte lanes enabled.
module data_sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

`ifdef DSRAM_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              merge_q, merge_d;
    logic              turn_q, turn_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [3:0]        be_n_q, be_n_d;
    logic [31:0]       merged;

    wire unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = sel_q[gi] ? wdata_q[8*gi +: 8] : sram_dq_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        turn_d  = turn_q;
        case (state_q)
            IDLE: begin
                if (ce_i) begin
                    addr_d  = addr_i[ADDR_W+1:2];
                    sel_d   = sel_i;
                    wdata_d = data_i;
                    cnt_d   = WAIT_INIT;
                    merge_d = 1'b0;
                    turn_d  = 1'b0;
                    if (!we_i) begin
                        state_d = RD;
                    end else if (sel_i == 4'b0000) begin
                        state_d = DONE;
                    end else if (RMW_EN && sel_i != 4'b1111) begin
                        state_d = RD;
                        merge_d = 1'b1;
                    end else begin
                        state_d = WR_SETUP;
                    end
                end
            end
            RD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = sram_dq_i;
                    if (merge_q) begin
                        wdata_d = merged;
                        turn_d  = 1'b1;
                        state_d = WR_SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WR_SETUP: begin
                // After a merge read, one extra setup cycle lets the SRAM release dq before we drive it.
                cnt_d  = WAIT_INIT;
                turn_d = 1'b0;
                if (!turn_q) begin
                    state_d = WR_PULSE;
                end
            end
            WR_PULSE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they are clean for the whole state.
        ce_n_d  = !(state_d == RD || state_d == WR_SETUP || state_d == WR_PULSE || state_d == WR_HOLD);
        oe_n_d  = !(state_d == RD);
        we_n_d  = !(state_d == WR_PULSE);
        dq_oe_d = (state_d == WR_PULSE || state_d == WR_HOLD || (state_d == WR_SETUP && !turn_d));
        be_n_d  = 4'b1111;
        if (state_d == RD) begin
            be_n_d = 4'b0000;
        end else if (state_d == WR_SETUP || state_d == WR_PULSE || state_d == WR_HOLD) begin
            be_n_d = RMW_EN ? 4'b0000 : ~sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            merge_q <= 1'b0;
            turn_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            be_n_q  <= 4'b1111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            turn_q  <= turn_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            be_n_q  <= be_n_d;
        end
    end

    assign stall_o     = !rst && ((state_q == IDLE && ce_i) || (state_q != IDLE && state_q != DONE));
    assign data_o      = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_dq_o   = wdata_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl with a small byte-lane SRAM model; expectations follow DSRAM_RMW_EN.
module tb_data_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_dq_i;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    data_sram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
        .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
        .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DSRAM_RMW_EN
    localparam int          SB_STALL  = 8;
    localparam logic [31:0] SB_WEMASK = 32'h60;
    localparam logic [3:0]  SB_BE     = 4'b0000;
    localparam logic [31:0] SB_DQ     = 32'hDE55BEEF;
`else
    localparam int          SB_STALL  = 5;
    localparam logic [31:0] SB_WEMASK = 32'h0C;
    localparam logic [3:0]  SB_BE     = 4'b1011;
    localparam logic [31:0] SB_DQ     = 32'h55555555;
`endif

    // SRAM model: 256 words, reads when selected, writes enabled lanes on clocks inside the we pulse.
    logic [31:0] mem [0:255];
    logic        mem_clr;
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[7:0]] : 32'h0BAD0BAD;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5000000 | 32'(i);
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
        end
    end

    int          total = 0;
    int          bad = 0;
    int          stall_cnt;
    int          done_cyc;
    logic [31:0] we_lo_mask, oe_lo_mask, ce_lo_mask, done_data, wr_dq, stall_bits;
    logic [3:0]  wr_be;
    logic [19:0] wr_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one request in the IDLE cycle after the next edge and observes it up to its DONE cycle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
        @(posedge clk); #1;
        ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
        stall_cnt = 0; done_cyc = -1; done_data = 32'h0;
        we_lo_mask = 32'h0; oe_lo_mask = 32'h0; ce_lo_mask = 32'h0;
        wr_be = 4'hF; wr_dq = 32'h0; wr_addr = 20'h0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (!sram_oe_n) oe_lo_mask[k] = 1'b1;
            if (!sram_ce_n) ce_lo_mask[k] = 1'b1;
            if (!sram_we_n) begin
                we_lo_mask[k] = 1'b1;
                wr_be = sram_be_n; wr_dq = sram_dq_o; wr_addr = sram_addr_o;
            end
            if (!stall_o) begin
                done_cyc = k; done_data = data_o;
                break;
            end
            @(posedge clk); #1;
            ce_i = 1'b0;
        end
        ce_i = 1'b0;
        $display("txn we=%0d addr=%h sel=%b data=%h stall=%0d done=%0d data_o=%h wemask=%h",
                 we, addr, sel, data, stall_cnt, done_cyc, done_data, we_lo_mask);
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; sel_i = 4'h0; data_i = 32'h0;
        repeat (3) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        check("rst_strobes", {24'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n}, 32'hEF);
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_data_o", data_o, 32'h0);
        check("rst_addr_dq", {12'h0, sram_addr_o} | sram_dq_o, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Full-word store
        txn(1'b1, 32'h00000010, 4'b1111, 32'hDEADBEEF);
        check("sw_stall", 32'(stall_cnt), 32'd5);
        check("sw_done", 32'(done_cyc), 32'd5);
        check("sw_wemask", we_lo_mask, 32'h0C);
        check("sw_be", {28'h0, wr_be}, 32'h0);
        check("sw_addr", {12'h0, wr_addr}, 32'h00004);
        check("sw_dq", wr_dq, 32'hDEADBEEF);

        // Load after store
        txn(1'b0, 32'h00000010, 4'b1111, 32'h0);
        check("lw_stall", 32'(stall_cnt), 32'd3);
        check("lw_done", 32'(done_cyc), 32'd3);
        check("lw_data", done_data, 32'hDEADBEEF);
        check("lw_wemask", we_lo_mask, 32'h0);
        check("lw_oemask", oe_lo_mask, 32'h06);

        // Byte store to offset 1 (lane 2)
        txn(1'b1, 32'h00000011, 4'b0100, 32'h55555555);
        check("sb_stall", 32'(stall_cnt), 32'(SB_STALL));
        check("sb_done", 32'(done_cyc), 32'(SB_STALL));
        check("sb_wemask", we_lo_mask, SB_WEMASK);
        check("sb_be", {28'h0, wr_be}, {28'h0, SB_BE});
        check("sb_dq", wr_dq, SB_DQ);
        check("sb_data_o", done_data, 32'hDEADBEEF);
        txn(1'b0, 32'h00000010, 4'b1111, 32'h0);
        check("sb_readback", done_data, 32'hDE55BEEF);

        // Zero-lane store
        txn(1'b1, 32'h00000010, 4'b0000, 32'hFFFFFFFF);
        check("sz_stall", 32'(stall_cnt), 32'd1);
        check("sz_done", 32'(done_cyc), 32'd1);
        check("sz_cemask", ce_lo_mask, 32'h0);
        txn(1'b0, 32'h00000010, 4'b1111, 32'h0);
        check("sz_readback", done_data, 32'hDE55BEEF);

        // Reset asserted during the write pulse
        @(posedge clk); #1;
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h00000020; sel_i = 4'b1111; data_i = 32'h12345678;
        @(posedge clk); #1 ce_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rm_in_pulse", {31'h0, sram_we_n}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rm_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rm_strobes", {24'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n}, 32'hEF);
        check("rm_data_o", data_o, 32'h0);
        $display("txn reset mid-store we_n=%b dq_oe=%b", sram_we_n, sram_dq_oe);
        @(posedge clk); #1 rst = 1'b0;
        txn(1'b0, 32'h00000040, 4'b1111, 32'h0);
        check("rm_load_stall", 32'(stall_cnt), 32'd3);
        check("rm_load_data", done_data, 32'hA5000010);

        // Back-to-back: load then store with ce_i held; inputs change after the load is accepted
        @(posedge clk); #1;
        ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h00000010; sel_i = 4'b1111; data_i = 32'h0;
        stall_bits = 32'h0; we_lo_mask = 32'h0; done_data = 32'h0; wr_addr = 20'h0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            stall_bits[k] = stall_o;
            if (!sram_we_n) begin
                we_lo_mask[k] = 1'b1; wr_addr = sram_addr_o;
            end
            if (k == 3) done_data = data_o;
            @(posedge clk); #1;
            if (k == 0) begin
                we_i = 1'b1; addr_i = 32'h00000030; data_i = 32'hCAFEF00D;
            end
            if (k == 4) ce_i = 1'b0;
        end
        $display("txn back-to-back stall_bits=%h wemask=%h", stall_bits, we_lo_mask);
        check("b2b_stall", stall_bits, 32'h1F7);
        check("b2b_load_data", done_data, 32'hDE55BEEF);
        check("b2b_wemask", we_lo_mask, 32'hC0);
        check("b2b_waddr", {12'h0, wr_addr}, 32'h0000C);
        txn(1'b0, 32'h00000030, 4'b1111, 32'h0);
        check("b2b_readback", done_data, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
